// File: rtl/double_tokens_if.sv
// Token-stream bundle for double_tokens: input token/clear toward the
// expander, expanded tokens and status back out.
interface double_tokens_if #(
  parameter int unsigned MAX_PENDING = 200
);
  localparam int unsigned PW = $clog2(MAX_PENDING + 1);

  logic          a;
  logic          overflow_clr;
  logic          b;
  logic [PW-1:0] pending;
  logic          busy;
  logic          overflow;

  modport master (
    output a,
    output overflow_clr,
    input  b,
    input  pending,
    input  busy,
    input  overflow
  );

  modport slave (
    input  a,
    input  overflow_clr,
    output b,
    output pending,
    output busy,
    output overflow
  );
endinterface

// File: rtl/double_tokens.sv
// Serial token expander: each input token on a becomes RATIO output tokens
// on b, one per cycle. Tokens not yet emitted are held in a saturating
// pending counter; a sticky flag records any tokens lost to saturation.
module double_tokens #(
  parameter  int unsigned RATIO       = 2,
  parameter  int unsigned MAX_PENDING = 200,
  localparam int unsigned PW          = $clog2(MAX_PENDING + 1)
) (
  input logic           clk,
  input logic           rst,
  double_tokens_if.slave bus
);

  // Five spare bits hold pending + RATIO (RATIO <= 16) without wrapping.
  localparam int unsigned XW = PW + 5;

  logic [PW-1:0] pending_q;
  logic          overflow_q;
  logic          has_pending;
  logic          emit;
  logic [XW-1:0] next_ext;
  logic          saturate;

  assign has_pending = (pending_q != '0);
  assign emit        = bus.a | has_pending;

  // Owed-token arithmetic: add the new expansion before removing the emitted token.
  always_comb begin
    next_ext = XW'(pending_q);
    if (bus.a) begin
      next_ext = next_ext + XW'(RATIO);
    end
    if (emit) begin
      next_ext = next_ext - XW'(1);
    end
    saturate = (next_ext > XW'(MAX_PENDING));
  end

  // Output token and busy decode, both held low while reset is asserted.
  always_comb begin
    bus.b    = 1'b0;
    bus.busy = 1'b0;
    if (!rst) begin
      bus.b    = emit;
      bus.busy = has_pending;
    end
  end

  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;

  // Pending counter with clamp, and sticky overflow where a new drop beats the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (saturate) begin
        pending_q  <= PW'(MAX_PENDING);
        overflow_q <= 1'b1;
      end else begin
        pending_q <= next_ext[PW-1:0];
        if (bus.overflow_clr) begin
          overflow_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_double_tokens.sv
// Self-checking bench for double_tokens: four configurations run side by side
// against an integer token-accounting reference model.
module tb_double_tokens;

  localparam int N = 4;
  localparam int unsigned RAT  [N] = '{2, 1, 2, 3};
  localparam int unsigned MAXP [N] = '{200, 200, 3, 200};

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] a;
  logic [N-1:0] clr;
  logic [N-1:0] obs_b;
  logic [N-1:0] obs_busy;
  logic [N-1:0] obs_ovf;
  logic [7:0]   obs_pend [N];
  logic [N-1:0] last_b;

  int unsigned  m_pend [N];
  logic [N-1:0] m_ovf;

  int unsigned  n_cmp = 0;
  int unsigned  n_bad = 0;

  int unsigned  t1_a [8] = '{1, 0, 0, 1, 1, 0, 0, 0};
  int unsigned  t1_b [8] = '{1, 1, 0, 1, 1, 1, 1, 0};
  int unsigned  t1_p [8] = '{1, 0, 0, 1, 2, 1, 0, 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    double_tokens_if #(.MAX_PENDING(MAXP[g])) bus ();
    double_tokens #(
      .RATIO       (RAT[g]),
      .MAX_PENDING (MAXP[g])
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign bus.a            = a[g];
    assign bus.overflow_clr = clr[g];
    assign obs_b[g]         = bus.b;
    assign obs_busy[g]      = bus.busy;
    assign obs_ovf[g]       = bus.overflow;
    assign obs_pend[g]      = 8'(bus.pending);
  end

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < N; g++) m_pend[g] = 0;
    m_ovf = '0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int g = 0; g < N; g++) begin
      check_val($sformatf("%s_b%0d", tag, g), obs_b[g], 0);
      check_val($sformatf("%s_busy%0d", tag, g), obs_busy[g], 0);
      check_val($sformatf("%s_pend%0d", tag, g), obs_pend[g], 0);
      check_val($sformatf("%s_ovf%0d", tag, g), obs_ovf[g], 0);
    end
  endtask

  // One clock cycle: drive, check outputs against the model, advance the model.
  task automatic step(input logic [N-1:0] av, input logic [N-1:0] cv);
    int unsigned owed;
    int unsigned eb;
    @(negedge clk);
    a   = av;
    clr = cv;
    #1;
    for (int g = 0; g < N; g++) begin
      eb = (av[g] || m_pend[g] != 0) ? 1 : 0;
      check_val($sformatf("b%0d", g), obs_b[g], eb);
      check_val($sformatf("busy%0d", g), obs_busy[g], (m_pend[g] != 0) ? 1 : 0);
      check_val($sformatf("pend%0d", g), obs_pend[g], m_pend[g]);
      check_val($sformatf("ovf%0d", g), obs_ovf[g], m_ovf[g]);
      last_b[g] = obs_b[g];
      owed = m_pend[g] + (av[g] ? RAT[g] : 0) - eb;
      if (owed > MAXP[g]) begin
        m_pend[g] = MAXP[g];
        m_ovf[g]  = 1'b1;
      end else begin
        m_pend[g] = owed;
        if (cv[g]) m_ovf[g] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    a   = '1;
    clr = '0;
    #1;
    check_all_zero("rst");
    model_reset();
    a = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a   = '0;
    clr = '0;
    last_b = '0;
    model_reset();
    #2 a = '1;
    #1;
    check_all_zero("por");
    a = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic expansion, RATIO=2
    for (int i = 0; i < 8; i++) begin
      step({3'b000, t1_a[i][0]}, '0);
      check_val($sformatf("t1_b[%0d]", i), last_b[0], t1_b[i]);
      check_val($sformatf("t1_pend[%0d]", i), obs_pend[0], t1_p[i]);
      check_val($sformatf("t1_ovf[%0d]", i), obs_ovf[0], 0);
    end

    // Random mix across all configurations
    for (int i = 0; i < 100; i++) begin
      logic [N-1:0] av;
      logic [N-1:0] cv;
      for (int g = 0; g < N; g++) begin
        av[g] = ($urandom_range(1, 0) == 1);
        cv[g] = ($urandom_range(7, 0) == 0);
      end
      step(av, cv);
      check_val("t2_passthru", last_b[1], a[1]);
    end

    // Saturation at MAX_PENDING=3
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step(4'b0100, '0);
      check_val($sformatf("t3_b[%0d]", i), last_b[2], 1);
      check_val($sformatf("t3_pend[%0d]", i), obs_pend[2], (i < 3) ? i + 1 : 3);
      check_val($sformatf("t3_ovf[%0d]", i), obs_ovf[2], (i >= 3) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) begin
      step('0, '0);
      check_val($sformatf("t3_drain_b[%0d]", i), last_b[2], (i < 3) ? 1 : 0);
    end

    // Overflow clear loses to a simultaneous drop, then clears when idle
    for (int i = 0; i < 3; i++) step(4'b0100, '0);
    step(4'b0100, 4'b0100);
    check_val("t4_set_wins", obs_ovf[2], 1);
    step('0, 4'b0100);
    check_val("t4_cleared", obs_ovf[2], 0);
    for (int i = 0; i < 3; i++) step('0, '0);

    // RATIO=3 single pulse
    apply_reset();
    step(4'b1000, '0);
    check_val("t5_b0", last_b[3], 1);
    check_val("t5_pend0", obs_pend[3], 2);
    check_val("t5_busy0", obs_busy[3], 1);
    step('0, '0);
    check_val("t5_b1", last_b[3], 1);
    check_val("t5_pend1", obs_pend[3], 1);
    check_val("t5_busy1", obs_busy[3], 1);
    step('0, '0);
    check_val("t5_b2", last_b[3], 1);
    check_val("t5_pend2", obs_pend[3], 0);
    check_val("t5_busy2", obs_busy[3], 0);
    step('0, '0);
    check_val("t5_b3", last_b[3], 0);

    // Asynchronous reset mid-burst discards owed tokens
    for (int i = 0; i < 3; i++) step(4'b0001, '0);
    check_val("t6_pre_pend", obs_pend[0], 3);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("t6_async");
    model_reset();
    @(negedge clk);
    a   = '0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step('0, '0);
      check_val($sformatf("t6_b[%0d]", i), last_b[0], 0);
    end

    // Dense random traffic driving the deep counter into saturation
    for (int i = 0; i < 700; i++) begin
      logic [N-1:0] av;
      logic [N-1:0] cv;
      for (int g = 0; g < N; g++) begin
        av[g] = ($urandom_range(3, 0) != 0);
        cv[g] = ($urandom_range(15, 0) == 0);
      end
      step(av, cv);
    end
    check_val("t7_sat_pend", obs_pend[0], m_pend[0]);
    for (int i = 0; i < 250; i++) step('0, '0);
    check_val("t7_drained", obs_pend[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/double_tokens.md
Name: double_tokens

Overview:
- Serial token expander: every '1' on `a` becomes RATIO '1's on `b`, emitted back-to-back at one token per cycle.
- Tokens that cannot be emitted immediately are held in a saturating pending counter.
- Sits in the serial-token path as the counterpart of the token-reducing stage; restores token density after a halving stage.
- Reports pending depth and a sticky overflow flag for when the counter saturates.

Parameters:
- RATIO, 2, output tokens generated per input token; legal range 1..16.
- MAX_PENDING, 200, maximum tokens the pending counter can hold; must be >= RATIO-1.
- PW, $clog2(MAX_PENDING+1), width of the pending counter (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous assert, active-high.
- a  input  1  input token stream; '1' = one token this cycle.
- overflow_clr  input  1  synchronous clear of the sticky overflow flag.
- b  output  1  output token stream; '1' = one token this cycle.
- pending  output  PW  tokens owed but not yet emitted (registered counter value).
- busy  output  1  high when pending != 0.
- overflow  output  1  sticky; set when tokens were dropped due to saturation.

Behaviour:
- Reset (async, rst=1):
  - pending=0, overflow=0.
  - b and busy are forced 0 while rst=1; a is ignored.
  - Reset mid-burst discards all owed tokens; there is no partial flush.
- Output (combinational, zero latency): b = a | (pending != 0).
  - The first token of an expansion appears in the same cycle as the input '1'.
- Counter update, per cycle:
  - Compute next = pending + (a ? RATIO : 0) - (b ? 1 : 0) in PW+5-bit arithmetic; no intermediate wrap.
  - If next > MAX_PENDING: pending <= MAX_PENDING, overflow <= 1 on the next edge, excess tokens dropped.
  - Otherwise: pending <= next.
- Never underflows: b=1 only when a token exists (a=1 or pending>0).
- RATIO=1: pending stays 0, b == a (pure pass-through), overflow never sets.
- Steady-state input density > 1/RATIO: pending grows monotonically until saturation.
- Overflow flag:
  - overflow_clr=1 clears it on the next edge.
  - Overflow event and overflow_clr in the same cycle: set wins, flag stays 1.
  - Flag stays 1 through any number of further saturations until cleared or reset.
- busy is a registered-equivalent decode: busy = (pending != 0), except forced 0 during reset.
- Design is fully synchronous apart from the async reset; deassertion is synchronised externally.

Test Plan:
1. Reset then RATIO=2, a = 1 0 0 1 1 0 0 0 -> b = 1 1 0 1 1 1 1 0; pending after each edge = 1 0 0 1 2 1 0 0; overflow stays 0.
2. RATIO=1, random a over 100 cycles -> b == a every cycle, pending == 0, busy == 0 throughout.
3. RATIO=2, MAX_PENDING=3, a held 1 -> b = 1 every cycle; pending = 1,2,3,3,3.
   - overflow rises the edge after the cycle where next = 4.
   - Drop a to 0 -> b stays 1 for exactly 3 cycles, then 0.
4. In saturated state with overflow=1, pulse overflow_clr while a=1 (still saturating) -> overflow stays 1. Then with a=0, pulse overflow_clr -> overflow = 0 on the next edge.
5. RATIO=3, single a pulse then a=0 -> b = 1 1 1 0; pending = 2,1,0; busy high for exactly 2 cycles after the pulse edge.
6. RATIO=2, a=1 1 1 (pending=3), assert rst asynchronously mid-cycle -> pending, b, busy, overflow all 0 immediately. After release with a=0 -> b stays 0 (owed tokens discarded).
